// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: one shared column datapath processes
// the four columns of a captured 128-bit state over four BUSY cycles.
module inv_mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   col_cnt;
    logic [127:0] in_reg;
    logic [127:0] res_reg;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply by k in {09,0b,0d,0e}, assembled from the xtime chain.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        col_in = in_reg[127:96];
        case (col_cnt)
            2'd1:    col_in = in_reg[95:64];
            2'd2:    col_in = in_reg[63:32];
            2'd3:    col_in = in_reg[31:0];
            default: col_in = in_reg[127:96];
        endcase
        col_out = inv_col(col_in);
    end

    // NOTE: the wide data registers are reset too, so an aborted operation never leaves a partial result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= 2'd0;
            in_reg  <= 128'h0;
            res_reg <= 128'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg  <= state_in;
                        col_cnt <= 2'd0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    case (col_cnt)
                        2'd0: res_reg[127:96] <= col_out;
                        2'd1: res_reg[95:64]  <= col_out;
                        2'd2: res_reg[63:32]  <= col_out;
                        2'd3: res_reg[31:0]   <= col_out;
                        default: ;
                    endcase
                    // NOTE: non-blocking updates keep col_cnt's old value visible to the slice select above.
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign state_out = res_reg;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: vector table, handshake corner
// cases and a forward-MixColumns round trip, with a queue-based scoreboard.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs[4];

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply, independent of the DUT's constant multipliers.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_fwd(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {
                gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
                a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
                a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
                gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
        end
        return r;
    endfunction

    // Scoreboard: every DONE cycle with out_ready=1 is one consumed result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h expected none", state_out);
            end else begin
                check("scoreboard", state_out, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready got in_ready=%b expected 1", in_ready);
        end
    endtask

    // Accepts one state; returns #1 after the accept edge.
    task automatic accept(input logic [127:0] din, input logic [127:0] exp);
        wait_ready();
        in_valid = 1'b1;
        state_in = din;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input logic [127:0] din, input logic [127:0] exp, input string name);
        int n;
        accept(din, exp);
        check({name, "_busy"}, {127'd0, busy}, 128'd1);
        check({name, "_in_ready_busy"}, {127'd0, in_ready}, 128'd0);
        wait_done(n);
        check({name, "_latency"}, 128'(n), 128'd4);
        @(posedge clk); #1;
        check({name, "_idle_after"}, {126'd0, in_ready, out_valid}, 128'b10);
    endtask

    initial begin
        logic [127:0] orig;
        logic [127:0] held;
        int n;
        int last_acc;
        int k;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff};
        vecs[2] = '{128'h0, 128'h0};
        // Columns of four equal bytes are fixed points (0e^0b^0d^09 = 01).
        vecs[3] = '{128'ha5a5a5a5_80808080_7f7f7f7f_1b1b1b1b, 128'ha5a5a5a5_80808080_7f7f7f7f_1b1b1b1b};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_flags", {125'd0, in_ready, busy, out_valid}, 128'b100);
        check("reset_state_out", state_out, 128'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));

        // Backpressure in DONE, with in_valid and out-of-phase data ignored.
        out_ready = 1'b0;
        accept(vecs[0].din, vecs[0].dout);
        wait_done(n);
        check("bp_latency", 128'(n), 128'd4);
        held = state_out;
        check("bp_held_value", held, vecs[0].dout);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("bp_out_valid", {127'd0, out_valid}, 128'd1);
            check("bp_in_ready", {127'd0, in_ready}, 128'd0);
            check("bp_state_out", state_out, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {126'd0, in_ready, out_valid}, 128'b10);

        // Input volatility during BUSY.
        accept(vecs[1].din, vecs[1].dout);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("vol_out_valid", {127'd0, out_valid}, 128'd1);
        @(posedge clk); #1;

        // Reset in the 2nd BUSY cycle discards the operation.
        accept(vecs[0].din, vecs[0].dout);
        @(posedge clk); #1;
        check("rst_mid_busy_before", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {125'd0, in_ready, busy, out_valid}, 128'b100);
        check("rst_mid_state_out", state_out, 128'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[1].din, vecs[1].dout, "after_rst");

        // Round trip through forward MixColumns, back-to-back with out_ready=1.
        // The accept period is IDLE + 4 BUSY + DONE = 6 edges (no bypass).
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            wait_ready();
            in_valid = 1'b1;
            state_in = mix_fwd(orig);
            exp_q.push_back(orig);
            @(posedge clk); #1;
            if (i > 0) check("throughput", 128'(cycle - last_acc), 128'd6);
            last_acc = cycle;
        end
        in_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_queue", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
